vpifo_push_pop_scheduler: RTL and testbench

//  Front-end scheduler for the virtualised PIFO task generator.
//  - Shares the single push port among NREQ ingress requesters with round-robin arbitration.
//  - Paces pops into the root tree.
//  - Tracks resident-entry occupancy and sequences a drain on request.
//  - Sits between the ingress ports and the task generator's push/pop/full interface.

---
 rtl/vpifo_push_pop_scheduler.sv | 163 ++++++++++++++++
 tb/tb_vpifo_push_pop_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpifo_push_pop_scheduler.sv
// Front-end scheduler for the virtualised PIFO task generator: round-robin push
// arbitration, paced pops, occupancy tracking and drain sequencing.
module vpifo_push_pop_scheduler #(
    parameter int NREQ     = 4,
    parameter int PTW      = 16,
    parameter int MTW      = 2,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int CTW      = 10,
    parameter int POP_GAP  = 2
) (
    input  logic                           i_clk,
    input  logic                           i_arst,
    input  logic [NREQ-1:0]                i_req_valid,
    output logic [NREQ-1:0]                o_req_ready,
    input  logic [NREQ*((TREE_NUM > 1) ? $clog2(TREE_NUM) : 1)-1:0] i_req_tree_id,
    input  logic [NREQ*PTW-1:0]            i_req_priority,
    input  logic [NREQ*(MTW+PTW)-1:0]      i_req_data,
    input  logic                           i_task_fifo_full,
    output logic                           o_push,
    output logic [((TREE_NUM > 1) ? $clog2(TREE_NUM) : 1)-1:0] o_push_tree_id,
    output logic [PTW-1:0]                 o_push_priority,
    output logic [MTW+PTW-1:0]             o_push_data,
    input  logic                           i_pop_req,
    output logic                           o_pop,
    input  logic                           i_drain,
    output logic                           o_drain_done,
    output logic [CTW-1:0]                 o_occupancy,
    output logic                           o_drop,
    output logic [CTW-1:0]                 o_drop_cnt
);

    localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int DW  = MTW + PTW;
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW  = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;
    localparam logic [CTW-1:0] OCC_MAX = {CTW{1'b1}};

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [CTW-1:0]  occ_q, occ_d;
    logic [CTW-1:0]  drop_cnt_q, drop_cnt_d;
    logic            push_q, push_d;
    logic            pop_q, pop_d;
    logic            drop_q, drop_d;
    logic [TNB-1:0]  tree_q, tree_d;
    logic [PTW-1:0]  prio_q, prio_d;
    logic [DW-1:0]   data_q, data_d;

    logic            grant_en;
    logic            found;
    logic            grant;
    logic            illegal;
    logic            pop_ok;
    logic [PW-1:0]   grant_idx;
    logic [TNB-1:0]  sel_tree;

    always_comb begin
        grant_en  = (state_q == ST_RUN) && !i_task_fifo_full &&
                    (({1'b0, occ_q} + (CTW+1)'(push_q)) < (CTW+1)'(OCC_MAX));
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_req_valid[(int'(rr_q) + k) % NREQ]) begin
                found     = 1'b1;
                grant_idx = PW'((int'(rr_q) + k) % NREQ);
            end
        end
        // Ready must read 0 while reset is held, even with requests pending.
        grant       = grant_en && found && !i_arst;
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[grant_idx] = 1'b1;
        end
        sel_tree = i_req_tree_id[grant_idx*TNB +: TNB];
        // Tree ids mapping onto the root RPU slot cannot be pushed.
        illegal  = (int'(sel_tree) % LEVEL) == 0;
        rr_d     = rr_q;
        if (grant) begin
            rr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        push_d     = grant && !illegal;
        drop_d     = grant && illegal;
        tree_d     = tree_q;
        prio_d     = prio_q;
        data_d     = data_q;
        if (push_d) begin
            tree_d = sel_tree;
            prio_d = i_req_priority[grant_idx*PTW +: PTW];
            data_d = i_req_data[grant_idx*DW +: DW];
        end
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != OCC_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        occ_d = occ_q + CTW'(push_q) - CTW'(pop_q);
    end

    always_comb begin
        // The pop about to be presented has not yet left occ_q, so discount it.
        pop_ok = (gap_q == '0) && (occ_q > CTW'(pop_q)) &&
                 (((state_q == ST_RUN) && i_pop_req) || (state_q == ST_DRAIN));
        pop_d  = pop_ok;
        gap_d  = gap_q;
        if (pop_ok) begin
            gap_d = GW'(POP_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (i_drain) state_d = ST_DRAIN;
            ST_DRAIN: if ((occ_q == '0) && !push_q && !pop_q) state_d = ST_DONE;
            ST_DONE:  if (!i_drain) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= ST_RUN;
            rr_q       <= '0;
            gap_q      <= '0;
            occ_q      <= '0;
            drop_cnt_q <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            drop_q     <= 1'b0;
            tree_q     <= '0;
            prio_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            drop_q     <= drop_d;
            tree_q     <= tree_d;
            prio_q     <= prio_d;
            data_q     <= data_d;
        end
    end

    assign o_push          = push_q;
    assign o_push_tree_id  = tree_q;
    assign o_push_priority = prio_q;
    assign o_push_data     = data_q;
    assign o_pop           = pop_q;
    assign o_drop          = drop_q;
    assign o_drop_cnt      = drop_cnt_q;
    assign o_occupancy     = occ_q;
    assign o_drain_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_vpifo_push_pop_scheduler.sv
// Scoreboard bench for vpifo_push_pop_scheduler: a per-cycle behavioural model
// queues expected push/drop/pop events; a monitor retires them as the DUT emits.
module tb_vpifo_push_pop_scheduler;

    localparam int NREQ = 4, PTW = 16, MTW = 3, LEVEL = 4, TREE_NUM = 8, CTW = 4, POP_GAP = 2;
    localparam int TNB = 3, DW = MTW + PTW, OCC_MAX = 15;

    logic                 clk = 1'b0;
    logic                 i_arst;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*TNB-1:0]  i_req_tree_id;
    logic [NREQ*PTW-1:0]  i_req_priority;
    logic [NREQ*DW-1:0]   i_req_data;
    logic                 i_task_fifo_full;
    logic                 o_push;
    logic [TNB-1:0]       o_push_tree_id;
    logic [PTW-1:0]       o_push_priority;
    logic [DW-1:0]        o_push_data;
    logic                 i_pop_req;
    logic                 o_pop;
    logic                 i_drain;
    logic                 o_drain_done;
    logic [CTW-1:0]       o_occupancy;
    logic                 o_drop;
    logic [CTW-1:0]       o_drop_cnt;

    vpifo_push_pop_scheduler #(
        .NREQ(NREQ), .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL),
        .TREE_NUM(TREE_NUM), .CTW(CTW), .POP_GAP(POP_GAP)
    ) dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_tree_id(i_req_tree_id), .i_req_priority(i_req_priority),
        .i_req_data(i_req_data), .i_task_fifo_full(i_task_fifo_full),
        .o_push(o_push), .o_push_tree_id(o_push_tree_id),
        .o_push_priority(o_push_priority), .o_push_data(o_push_data),
        .i_pop_req(i_pop_req), .o_pop(o_pop),
        .i_drain(i_drain), .o_drain_done(o_drain_done),
        .o_occupancy(o_occupancy), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              c;
        logic [TNB-1:0]  t;
        logic [PTW-1:0]  p;
        logic [DW-1:0]   d;
    } push_t;

    push_t push_exp[$];
    int    drop_exp[$];
    int    pop_exp[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit in_rst  = 1'b1;

    // Model state: values the DUT's registers should hold this cycle.
    int m_rr, m_occ, m_gap, m_st, m_cnt;   // m_st: 0 run, 1 drain, 2 done
    bit m_push, m_pop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_occ = 0; m_gap = 0; m_st = 0; m_cnt = 0;
        m_push = 1'b0; m_pop = 1'b0;
        push_exp.delete(); drop_exp.delete(); pop_exp.delete();
    endtask

    task automatic model_step();
        int g, t, j, cnt_n, nst;
        bit ge, pop_ok, new_push;
        logic [NREQ-1:0] exp_rdy;
        push_t e;
        ge = (m_st == 0) && !i_task_fifo_full && (m_occ + int'(m_push) < OCC_MAX);
        g = -1;
        if (ge) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_rr + k) % NREQ;
                if (g < 0 && i_req_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        chk("occupancy", 32'(o_occupancy), 32'(m_occ));
        chk("drain_done", 32'(o_drain_done), 32'(m_st == 2));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_cnt));
        new_push = 1'b0;
        cnt_n = m_cnt;
        if (g >= 0) begin
            m_rr = (g + 1) % NREQ;
            t = int'(i_req_tree_id[g*TNB +: TNB]);
            if (t % LEVEL == 0) begin
                drop_exp.push_back(cyc);
                cnt_n = (m_cnt < OCC_MAX) ? m_cnt + 1 : OCC_MAX;
            end else begin
                e.c = cyc;
                e.t = i_req_tree_id[g*TNB +: TNB];
                e.p = i_req_priority[g*PTW +: PTW];
                e.d = i_req_data[g*DW +: DW];
                push_exp.push_back(e);
                new_push = 1'b1;
            end
        end
        pop_ok = (m_gap == 0) && (m_occ > int'(m_pop)) &&
                 (((m_st == 0) && i_pop_req) || (m_st == 1));
        if (pop_ok) pop_exp.push_back(cyc);
        nst = m_st;
        if (m_st == 0 && i_drain) nst = 1;
        else if (m_st == 1 && m_occ == 0 && !m_push && !m_pop) nst = 2;
        else if (m_st == 2 && !i_drain) nst = 0;
        m_st  = nst;
        m_occ = m_occ + int'(m_push) - int'(m_pop);
        m_push = new_push;
        m_pop  = pop_ok;
        m_gap  = pop_ok ? POP_GAP - 1 : ((m_gap > 0) ? m_gap - 1 : 0);
        m_cnt  = cnt_n;
    endtask

    always @(negedge clk) if (!in_rst) model_step();

    // Monitor: retire queued expectations when the DUT emits, and flag late ones.
    always @(negedge clk) begin
        push_t e;
        int c;
        if (!in_rst) begin
            if (o_push) begin
                if (push_exp.size() == 0) chk("push_unexpected", 32'(o_push), 32'd0);
                else begin
                    e = push_exp.pop_front();
                    chk("push_latency", 32'(cyc), 32'(e.c + 1));
                    chk("push_tree", 32'(o_push_tree_id), 32'(e.t));
                    chk("push_prio", 32'(o_push_priority), 32'(e.p));
                    chk("push_data", 32'(o_push_data), 32'(e.d));
                end
            end
            while (push_exp.size() > 0 && push_exp[0].c + 1 < cyc) begin
                e = push_exp.pop_front();
                chk("push_missing", 32'd0, 32'd1);
            end
            if (o_drop) begin
                if (drop_exp.size() == 0) chk("drop_unexpected", 32'(o_drop), 32'd0);
                else begin
                    c = drop_exp.pop_front();
                    chk("drop_latency", 32'(cyc), 32'(c + 1));
                end
            end
            while (drop_exp.size() > 0 && drop_exp[0] + 1 < cyc) begin
                c = drop_exp.pop_front();
                chk("drop_missing", 32'd0, 32'd1);
            end
            if (o_pop) begin
                if (pop_exp.size() == 0) chk("pop_unexpected", 32'(o_pop), 32'd0);
                else begin
                    c = pop_exp.pop_front();
                    chk("pop_latency", 32'(cyc), 32'(c + 1));
                end
            end
            while (pop_exp.size() > 0 && pop_exp[0] + 1 < cyc) begin
                c = pop_exp.pop_front();
                chk("pop_missing", 32'd0, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input int tree);
        i_req_valid[i] = v;
        i_req_tree_id[i*TNB +: TNB] = TNB'(tree);
        i_req_priority[i*PTW +: PTW] = PTW'($urandom);
        i_req_data[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic drive_rand(input int pv, input int pf, input int pp);
        for (int i = 0; i < NREQ; i++) set_req(i, ($urandom_range(0, 99) < pv), $urandom_range(0, 7));
        i_task_fifo_full = ($urandom_range(0, 99) < pf);
        i_pop_req        = ($urandom_range(0, 99) < pp);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_push", 32'(o_push), 32'd0);
        chk("rst_push_fields", 32'(o_push_tree_id) | 32'(o_push_priority) | 32'(o_push_data), 32'd0);
        chk("rst_pop", 32'(o_pop), 32'd0);
        chk("rst_occ", 32'(o_occupancy), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        chk("rst_drain_done", 32'(o_drain_done), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        model_reset();
        i_arst = 1'b0;
        in_rst = 1'b0;
    endtask

    initial begin
        int drain_left;
        bit seen;
        i_arst = 1'b1;
        i_drain = 1'b0;
        drive_rand(100, 0, 100);
        #12;
        check_reset_outputs();
        release_reset();

        // Round robin with every requester valid on legal trees.
        set_req(0, 1, 1); set_req(1, 1, 2); set_req(2, 1, 3); set_req(3, 1, 1);
        i_task_fifo_full = 1'b0; i_pop_req = 1'b0;
        repeat (5) tick();
        // Illegal trees 0 and 4 on requester 0.
        i_req_valid = '0;
        set_req(0, 1, 0); tick();
        set_req(0, 1, 4); tick();
        i_req_valid = '0;
        // Backpressure holds grants and the pointer.
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 5 + (i % 3));
        i_task_fifo_full = 1'b1; repeat (3) tick();
        i_task_fifo_full = 1'b0; repeat (2) tick();
        // Drain with pops idle downstream; requests arrive but must be refused.
        i_req_valid = '0; i_pop_req = 1'b0; i_drain = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            drive_rand(80, 0, 0);
            tick();
            seen = o_drain_done;
        end
        chk("drain_reached", 32'(seen), 32'd1);
        repeat (3) begin drive_rand(80, 0, 0); tick(); end
        i_drain = 1'b0;
        repeat (3) begin drive_rand(60, 0, 50); tick(); end

        // Randomised traffic with occasional drains of random length.
        drain_left = 0;
        for (int n = 0; n < 700; n++) begin
            drive_rand(60, 25, 50);
            if (drain_left > 0) drain_left--;
            else if ($urandom_range(0, 99) < 3) drain_left = $urandom_range(1, 20);
            i_drain = (drain_left > 0);
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        drive_rand(100, 0, 100);
        i_drain = 1'b0;
        @(posedge clk);
        #3;
        in_rst = 1'b1;
        i_arst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        release_reset();
        for (int n = 0; n < 200; n++) begin
            drive_rand(70, 20, 40);
            tick();
        end

        // Let everything retire.
        i_req_valid = '0; i_drain = 1'b0; i_task_fifo_full = 1'b0; i_pop_req = 1'b1;
        repeat (40) tick();
        chk("end_occupancy", 32'(o_occupancy), 32'd0);
        chk("end_queues", 32'(push_exp.size() + drop_exp.size() + pop_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
